// File: rtl/param_mux_if.sv
// Bus bundle for the param_mux select stage: packed input lanes and select
// in one direction, registered lane and out-of-range flag back.
interface param_mux_if #(
  parameter int NUM_INPUT  = 4,
  parameter int SEL_WIDTH  = 2,
  parameter int DATA_WIDTH = 1
);
  logic [DATA_WIDTH*NUM_INPUT-1:0] data_in;
  logic [SEL_WIDTH-1:0]            sel;
  logic [DATA_WIDTH-1:0]           data_out;
  logic                            sel_err;

  modport master (
    output data_in,
    output sel,
    input  data_out,
    input  sel_err
  );

  modport slave (
    input  data_in,
    input  sel,
    output data_out,
    output sel_err
  );
endinterface

// File: rtl/param_mux.sv
// N:1 word multiplexer with a registered output. A select code that addresses
// no lane produces zero data and raises sel_err for that cycle.
module param_mux #(
  parameter int NUM_INPUT  = 4,
  parameter int SEL_WIDTH  = 2,
  parameter int DATA_WIDTH = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  param_mux_if.slave  bus
);

  if (NUM_INPUT < 1) begin : g_badNumInput
    $error("param_mux: NUM_INPUT must be at least 1");
  end
  if (DATA_WIDTH < 1) begin : g_badDataWidth
    $error("param_mux: DATA_WIDTH must be at least 1");
  end
  if (SEL_WIDTH < 1 || NUM_INPUT > (2 ** SEL_WIDTH)) begin : g_badSelWidth
    $error("param_mux: SEL_WIDTH too narrow to address NUM_INPUT lanes");
  end

  logic [DATA_WIDTH-1:0] outData_d;
  logic [DATA_WIDTH-1:0] outData_q;
  logic                  selErr_d;
  logic                  selErr_q;

  // Unmatched select codes fall through to zero data with the error set,
  // so unused codes never leak X into the pipeline.
  always_comb begin
    outData_d = '0;
    selErr_d  = 1'b1;
    for (int i = 0; i < NUM_INPUT; i++) begin
      if (bus.sel == SEL_WIDTH'(i)) begin
        outData_d = bus.data_in[i*DATA_WIDTH +: DATA_WIDTH];
        selErr_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outData_q <= '0;
      selErr_q  <= 1'b0;
    end else begin
      outData_q <= outData_d;
      selErr_q  <= selErr_d;
    end
  end

  assign bus.data_out = outData_q;
  assign bus.sel_err  = selErr_q;

endmodule

// File: tb/tb_param_mux.sv
// Directed bench for param_mux across four parameter sets; inputs change on
// the falling edge and outputs are checked on the falling edge as well.
module tb_param_mux;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  param_mux_if #(.NUM_INPUT(4), .SEL_WIDTH(2), .DATA_WIDTH(1))  ifA ();
  param_mux_if #(.NUM_INPUT(3), .SEL_WIDTH(2), .DATA_WIDTH(8))  ifB ();
  param_mux_if #(.NUM_INPUT(4), .SEL_WIDTH(2), .DATA_WIDTH(16)) ifC ();
  param_mux_if #(.NUM_INPUT(1), .SEL_WIDTH(1), .DATA_WIDTH(4))  ifD ();

  param_mux #(.NUM_INPUT(4), .SEL_WIDTH(2), .DATA_WIDTH(1))
    dutA (.clk(clk), .rst_n(rst_n), .bus(ifA));
  param_mux #(.NUM_INPUT(3), .SEL_WIDTH(2), .DATA_WIDTH(8))
    dutB (.clk(clk), .rst_n(rst_n), .bus(ifB));
  param_mux #(.NUM_INPUT(4), .SEL_WIDTH(2), .DATA_WIDTH(16))
    dutC (.clk(clk), .rst_n(rst_n), .bus(ifC));
  param_mux #(.NUM_INPUT(1), .SEL_WIDTH(1), .DATA_WIDTH(4))
    dutD (.clk(clk), .rst_n(rst_n), .bus(ifD));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    ifA.data_in = 4'b1010;
    ifA.sel     = 2'd1;
    ifB.data_in = 24'h332211;
    ifB.sel     = 2'd3;
    #1;
    vectors++;
    if (ifA.data_out !== 1'b0 || ifA.sel_err !== 1'b0) begin
      $display("[TB] FAIL reset_async: data_out=%b sel_err=%b, expected 0 0", ifA.data_out, ifA.sel_err);
      miscompares++;
    end
    @(posedge clk); #1;
    vectors++;
    if (ifA.data_out !== 1'b0 || ifA.sel_err !== 1'b0) begin
      $display("[TB] FAIL reset_hold: data_out=%b sel_err=%b, expected 0 0", ifA.data_out, ifA.sel_err);
      miscompares++;
    end
    vectors++;
    if (ifB.data_out !== 8'h00 || ifB.sel_err !== 1'b0) begin
      $display("[TB] FAIL reset_hold_err: data_out=%h sel_err=%b, expected 00 0", ifB.data_out, ifB.sel_err);
      miscompares++;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sweep();
    logic [3:0] expLane;
    expLane = 4'b1010;
    ifA.data_in = 4'b1010;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      ifA.sel = 2'(s);
      @(negedge clk);
      vectors++;
      if (ifA.data_out !== expLane[s] || ifA.sel_err !== 1'b0) begin
        $display("[TB] FAIL sweep_sel%0d: data_out=%b sel_err=%b, expected %b 0", s, ifA.data_out, ifA.sel_err, expLane[s]);
        miscompares++;
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [7:0] expData [3];
    logic       expErr  [3];
    logic [1:0] selSeq  [3];
    selSeq[0] = 2'd2; expData[0] = 8'h33; expErr[0] = 1'b0;
    selSeq[1] = 2'd3; expData[1] = 8'h00; expErr[1] = 1'b1;
    selSeq[2] = 2'd0; expData[2] = 8'h11; expErr[2] = 1'b0;
    ifB.data_in = {8'h33, 8'h22, 8'h11};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      ifB.sel = selSeq[k];
      @(negedge clk);
      vectors++;
      if (ifB.data_out !== expData[k] || ifB.sel_err !== expErr[k]) begin
        $display("[TB] FAIL range_sel%0d: data_out=%h sel_err=%b, expected %h %b", selSeq[k], ifB.data_out, ifB.sel_err, expData[k], expErr[k]);
        miscompares++;
      end
    end
  endtask

  task automatic test_lane_isolation();
    @(negedge clk);
    ifA.sel     = 2'd1;
    ifA.data_in = 4'b1010;
    @(negedge clk);
    ifA.data_in = 4'b1111;
    @(negedge clk);
    vectors++;
    if (ifA.data_out !== 1'b1) begin
      $display("[TB] FAIL isolate_toggle_on: data_out=%b, expected 1", ifA.data_out);
      miscompares++;
    end
    ifA.data_in = 4'b1010;
    @(negedge clk);
    vectors++;
    if (ifA.data_out !== 1'b1) begin
      $display("[TB] FAIL isolate_toggle_off: data_out=%b, expected 1", ifA.data_out);
      miscompares++;
    end
    ifA.data_in = 4'b1000;
    #1;
    vectors++;
    if (ifA.data_out !== 1'b1) begin
      $display("[TB] FAIL isolate_early: data_out=%b, expected 1 before edge", ifA.data_out);
      miscompares++;
    end
    @(negedge clk);
    vectors++;
    if (ifA.data_out !== 1'b0) begin
      $display("[TB] FAIL isolate_selected: data_out=%b, expected 0", ifA.data_out);
      miscompares++;
    end
  endtask

  task automatic test_midstream_reset();
    @(negedge clk);
    ifA.sel     = 2'd1;
    ifA.data_in = 4'b1010;
    @(negedge clk);
    vectors++;
    if (ifA.data_out !== 1'b1) begin
      $display("[TB] FAIL midreset_pre: data_out=%b, expected 1", ifA.data_out);
      miscompares++;
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (ifA.data_out !== 1'b0) begin
      $display("[TB] FAIL midreset_async: data_out=%b, expected 0", ifA.data_out);
      miscompares++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (ifA.data_out !== 1'b0) begin
      $display("[TB] FAIL midreset_release: data_out=%b, expected 0", ifA.data_out);
      miscompares++;
    end
    @(negedge clk);
    vectors++;
    if (ifA.data_out !== 1'b1) begin
      $display("[TB] FAIL midreset_recapture: data_out=%b, expected 1", ifA.data_out);
      miscompares++;
    end
  endtask

  task automatic test_lane_order();
    logic [15:0] expWord;
    ifC.data_in = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      ifC.sel = 2'(s);
      expWord = 16'hA000 + 16'(s);
      @(negedge clk);
      vectors++;
      if (ifC.data_out !== expWord || ifC.sel_err !== 1'b0) begin
        $display("[TB] FAIL order_sel%0d: data_out=%h sel_err=%b, expected %h 0", s, ifC.data_out, ifC.sel_err, expWord);
        miscompares++;
      end
    end
  endtask

  task automatic test_single_lane();
    ifD.data_in = 4'h9;
    @(negedge clk);
    ifD.sel = 1'b0;
    @(negedge clk);
    vectors++;
    if (ifD.data_out !== 4'h9 || ifD.sel_err !== 1'b0) begin
      $display("[TB] FAIL single_sel0: data_out=%h sel_err=%b, expected 9 0", ifD.data_out, ifD.sel_err);
      miscompares++;
    end
    ifD.sel = 1'b1;
    @(negedge clk);
    vectors++;
    if (ifD.data_out !== 4'h0 || ifD.sel_err !== 1'b1) begin
      $display("[TB] FAIL single_sel1: data_out=%h sel_err=%b, expected 0 1", ifD.data_out, ifD.sel_err);
      miscompares++;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    ifA.data_in = '0; ifA.sel = '0;
    ifB.data_in = '0; ifB.sel = '0;
    ifC.data_in = '0; ifC.sel = '0;
    ifD.data_in = '0; ifD.sel = '0;
    test_reset();
    test_sweep();
    test_out_of_range();
    test_lane_isolation();
    test_midstream_reset();
    test_lane_order();
    test_single_lane();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
